// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants, execute-scheduler state encoding and the per-op metadata
// carried from issue to writeback.
package cpu_isa_pkg;

   localparam int OP_W   = 4;
   localparam int REG_AW = 5;

   localparam logic [OP_W-1:0] ISA_ADD_OP = 4'h0;
   localparam logic [OP_W-1:0] ISA_SUB_OP = 4'h1;
   localparam logic [OP_W-1:0] ISA_MUL_OP = 4'h2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } exec_state_t;

   typedef struct packed {
      logic [REG_AW-1:0] reg_dest;
      logic              reg_write;
      logic              commit;
      logic              sel;
      logic              illegal;
   } exec_meta_t;

   function automatic logic is_alu_op(input logic [OP_W-1:0] op);
      return (op == ISA_ADD_OP) || (op == ISA_SUB_OP);
   endfunction

endpackage

// File: rtl/cpu_exec_latency_counter.sv
// Loadable down-counter that tracks remaining MUL cycles; zero flags the last
// busy cycle.
module cpu_exec_latency_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/cpu_execute_scheduler.sv
// Issue controller for the execute stage: starts the ALU or MUL, stalls decode
// while a MUL is in flight and produces one in-order writeback strobe per op.
module cpu_execute_scheduler
   import cpu_isa_pkg::*;
#(
   parameter int MUL_LATENCY = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [OP_W-1:0]   issue_op,
   input  logic [REG_AW-1:0] issue_reg_dest,
   input  logic              issue_reg_write,
   input  logic              issue_commit,
   output logic              alu_start,
   output logic              alu_sub,
   output logic              mul_start,
   output logic              wb_valid,
   output logic              wb_sel_mul,
   output logic [REG_AW-1:0] wb_reg_dest,
   output logic              wb_reg_write,
   output logic              wb_commit,
   output logic              illegal_op
);

   localparam int CNT_W = $clog2(MUL_LATENCY);

   exec_state_t      state_reg, state_next;
   exec_meta_t       meta_reg, meta_next;
   logic             quick_wb_reg, quick_wb_next;
   logic             mul_wb;
   logic             issue_accept;
   logic             op_is_alu, op_is_mul;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_load_value;

   assign op_is_alu = is_alu_op(issue_op);
   assign op_is_mul = (issue_op == ISA_MUL_OP);

   cpu_exec_latency_counter #(
      .WIDTH(CNT_W)
   ) u_latency_counter (
      .clock      (clock),
      .reset      (reset),
      .load       (cnt_load),
      .load_value (cnt_load_value),
      .dec        (cnt_dec),
      .zero       (cnt_zero)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         meta_reg     <= '0;
         quick_wb_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         meta_reg     <= meta_next;
         quick_wb_reg <= quick_wb_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      meta_next      = meta_reg;
      quick_wb_next  = 1'b0;
      mul_wb         = 1'b0;
      cnt_load       = 1'b0;
      cnt_load_value = '0;
      cnt_dec        = 1'b0;
      issue_ready    = !reset && !flush && (state_reg != MUL_BUSY);
      issue_accept   = issue_valid && issue_ready;
      alu_start      = 1'b0;
      alu_sub        = 1'b0;
      mul_start      = 1'b0;

      case (state_reg)
         MUL_BUSY: begin
            if (cnt_zero) begin
               state_next = MUL_DONE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            // MUL_DONE strobes its result and still accepts a new op, as IDLE does.
            mul_wb     = (state_reg == MUL_DONE);
            state_next = IDLE;
            if (issue_accept) begin
               meta_next = exec_meta_t'{
                  reg_dest:  issue_reg_dest,
                  reg_write: issue_reg_write && (op_is_alu || op_is_mul),
                  commit:    issue_commit,
                  sel:       op_is_mul,
                  illegal:   !(op_is_alu || op_is_mul)
               };
               if (op_is_mul) begin
                  mul_start      = 1'b1;
                  cnt_load       = 1'b1;
                  cnt_load_value = CNT_W'(MUL_LATENCY - 2);
                  state_next     = MUL_BUSY;
               end else begin
                  quick_wb_next = 1'b1;
                  alu_start     = op_is_alu;
                  alu_sub       = (issue_op == ISA_SUB_OP);
               end
            end
         end
      endcase

      if (flush) begin
         state_next     = IDLE;
         cnt_load       = 1'b1;
         cnt_load_value = '0;
         quick_wb_next  = 1'b0;
         mul_wb         = 1'b0;
      end
   end

   assign wb_valid     = !reset && (quick_wb_reg || mul_wb);
   assign wb_sel_mul   = wb_valid && meta_reg.sel;
   assign wb_reg_dest  = wb_valid ? meta_reg.reg_dest : '0;
   assign wb_reg_write = wb_valid && meta_reg.reg_write;
   assign wb_commit    = wb_valid && meta_reg.commit;
   assign illegal_op   = wb_valid && meta_reg.illegal;

endmodule

// File: tb/tb_cpu_execute_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// event-list model of issue acceptance and writeback timing.
module tb_cpu_execute_scheduler;
   import cpu_isa_pkg::*;

   localparam int LAT = 4;

   logic clock = 1'b0;
   logic reset, flush, issue_valid, issue_reg_write, issue_commit;
   logic [OP_W-1:0]   issue_op;
   logic [REG_AW-1:0] issue_reg_dest;

   logic issue_ready, alu_start, alu_sub, mul_start;
   logic wb_valid, wb_sel_mul, wb_reg_write, wb_commit, illegal_op;
   logic [REG_AW-1:0] wb_reg_dest;

   logic l2_issue_ready, l2_alu_start, l2_alu_sub, l2_mul_start;
   logic l2_wb_valid, l2_wb_sel_mul, l2_wb_reg_write, l2_wb_commit, l2_illegal_op;
   logic [REG_AW-1:0] l2_wb_reg_dest;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   cpu_execute_scheduler #(.MUL_LATENCY(LAT)) dut (
      .clock(clock), .reset(reset), .flush(flush), .issue_valid(issue_valid),
      .issue_ready(issue_ready), .issue_op(issue_op), .issue_reg_dest(issue_reg_dest),
      .issue_reg_write(issue_reg_write), .issue_commit(issue_commit),
      .alu_start(alu_start), .alu_sub(alu_sub), .mul_start(mul_start),
      .wb_valid(wb_valid), .wb_sel_mul(wb_sel_mul), .wb_reg_dest(wb_reg_dest),
      .wb_reg_write(wb_reg_write), .wb_commit(wb_commit), .illegal_op(illegal_op)
   );

   cpu_execute_scheduler #(.MUL_LATENCY(2)) dut_l2 (
      .clock(clock), .reset(reset), .flush(flush), .issue_valid(issue_valid),
      .issue_ready(l2_issue_ready), .issue_op(issue_op), .issue_reg_dest(issue_reg_dest),
      .issue_reg_write(issue_reg_write), .issue_commit(issue_commit),
      .alu_start(l2_alu_start), .alu_sub(l2_alu_sub), .mul_start(l2_mul_start),
      .wb_valid(l2_wb_valid), .wb_sel_mul(l2_wb_sel_mul), .wb_reg_dest(l2_wb_reg_dest),
      .wb_reg_write(l2_wb_reg_write), .wb_commit(l2_wb_commit), .illegal_op(l2_illegal_op)
   );

   // ctl = {issue_ready, alu_start, alu_sub, mul_start}
   // wbv = {wb_valid, wb_sel_mul, wb_reg_dest, wb_reg_write, wb_commit, illegal_op}
   wire [3:0] ctl = {issue_ready, alu_start, alu_sub, mul_start};
   wire [9:0] wbv = {wb_valid, wb_sel_mul, wb_reg_dest, wb_reg_write, wb_commit, illegal_op};
   wire [9:0] l2_wbv = {l2_wb_valid, l2_wb_sel_mul, l2_wb_reg_dest, l2_wb_reg_write,
                        l2_wb_commit, l2_illegal_op};

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [OP_W-1:0] op, input logic [REG_AW-1:0] d,
                        input logic w, input logic c);
      issue_valid     = v;
      issue_op        = op;
      issue_reg_dest  = d;
      issue_reg_write = w;
      issue_commit    = c;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      drive(1'b1, ISA_MUL_OP, 5'd1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         tests_run++;
         if ({issue_ready, alu_start, mul_start, wb_valid, wb_reg_write, wb_commit, illegal_op,
              l2_issue_ready, l2_mul_start, l2_wb_valid} !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs cycle %0d got ready=%b alu=%b mul=%b wb=%b want all 0",
                     i, issue_ready, alu_start, mul_start, wb_valid);
         end
         tick();
      end
      reset = 1'b0;
      drive(1'b0, ISA_ADD_OP, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
      tests_run++;
      if ({issue_ready, wb_valid, wb_reg_write, wb_commit} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL reset_release got ready=%b wb=%b want ready=1 wb=0", issue_ready, wb_valid);
      end
      tick();
   endtask

   task automatic test_alu_back_to_back();
      drive(1'b1, ISA_ADD_OP, 5'd3, 1'b1, 1'b1);
      @(negedge clock);
      tests_run++;
      if (ctl !== 4'b1100 || wb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL alu_add_issue got ctl=%b wb=%b want ctl=1100 wb=0", ctl, wb_valid);
      end
      tick();
      drive(1'b1, ISA_SUB_OP, 5'd4, 1'b1, 1'b0);
      @(negedge clock);
      tests_run++;
      if (ctl !== 4'b1110 || wbv !== {1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL alu_sub_issue got ctl=%b wbv=%b want ctl=1110 wbv=%b", ctl, wbv,
                  {1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0});
      end
      tick();
      drive(1'b0, ISA_ADD_OP, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
      tests_run++;
      if (wbv !== {1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL alu_sub_wb got %b want %b", wbv, {1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0});
      end
      tick();
      @(negedge clock);
      tests_run++;
      if ({wb_valid, wb_reg_write, wb_commit} !== 3'b000) begin
         tests_failed++;
         $display("FAIL alu_idle_wb got %b want 000", {wb_valid, wb_reg_write, wb_commit});
      end
      tick();
   endtask

   task automatic test_mul_stall();
      drive(1'b1, ISA_MUL_OP, 5'd7, 1'b1, 1'b1);
      @(negedge clock);
      tests_run++;
      if (ctl !== 4'b1001 || wb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mul_issue got ctl=%b wb=%b want ctl=1001 wb=0", ctl, wb_valid);
      end
      tick();
      drive(1'b1, ISA_ADD_OP, 5'd2, 1'b1, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         tests_run++;
         if (ctl !== 4'b0000 || wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul_stall cycle %0d got ctl=%b wb=%b want ctl=0000 wb=0", c, ctl, wb_valid);
         end
         tick();
      end
      @(negedge clock);
      tests_run++;
      if (ctl !== 4'b1100 || wbv !== {1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL mul_done got ctl=%b wbv=%b want ctl=1100 wbv=%b", ctl, wbv,
                  {1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0});
      end
      tick();
      drive(1'b0, ISA_ADD_OP, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
      tests_run++;
      if (ctl !== 4'b1000 || wbv !== {1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL mul_then_add_wb got ctl=%b wbv=%b want ctl=1000 wbv=%b", ctl, wbv,
                  {1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0});
      end
      tick();
   endtask

   task automatic test_flush_mul();
      drive(1'b1, ISA_MUL_OP, 5'd5, 1'b1, 1'b1);
      tick();
      drive(1'b0, ISA_ADD_OP, 5'd0, 1'b0, 1'b0);
      tick();
      flush = 1'b1;
      drive(1'b1, ISA_MUL_OP, 5'd6, 1'b1, 1'b1);
      @(negedge clock);
      tests_run++;
      if (ctl !== 4'b0000 || wb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_cycle got ctl=%b wb=%b want ctl=0000 wb=0", ctl, wb_valid);
      end
      tick();
      flush = 1'b0;
      @(negedge clock);
      tests_run++;
      if (ctl !== 4'b1001 || wb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_recover got ctl=%b wb=%b want ctl=1001 wb=0", ctl, wb_valid);
      end
      tick();
      drive(1'b0, ISA_ADD_OP, 5'd0, 1'b0, 1'b0);
      for (int c = 4; c <= 6; c++) begin
         @(negedge clock);
         tests_run++;
         if (issue_ready !== 1'b0 || wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_new_mul_busy cycle %0d got ready=%b wb=%b want 0 0",
                     c, issue_ready, wb_valid);
         end
         tick();
      end
      @(negedge clock);
      tests_run++;
      if (issue_ready !== 1'b1 || wbv !== {1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL flush_new_mul_wb got ready=%b wbv=%b want ready=1 wbv=%b", issue_ready, wbv,
                  {1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0});
      end
      tick();
      // Flush landing exactly in the MUL result cycle.
      drive(1'b1, ISA_MUL_OP, 5'd1, 1'b0, 1'b1);
      tick();
      drive(1'b0, ISA_ADD_OP, 5'd0, 1'b0, 1'b0);
      for (int c = 0; c < LAT - 1; c++) tick();
      flush = 1'b1;
      @(negedge clock);
      tests_run++;
      if (issue_ready !== 1'b0 || wb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_in_done got ready=%b wb=%b want 0 0", issue_ready, wb_valid);
      end
      tick();
      flush = 1'b0;
      @(negedge clock);
      tests_run++;
      if (issue_ready !== 1'b1 || wb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_after_done got ready=%b wb=%b want 1 0", issue_ready, wb_valid);
      end
      tick();
   endtask

   task automatic test_illegal();
      drive(1'b1, 4'hF, 5'd9, 1'b1, 1'b1);
      @(negedge clock);
      tests_run++;
      if (ctl !== 4'b1000) begin
         tests_failed++;
         $display("FAIL illegal_issue got ctl=%b want 1000", ctl);
      end
      tick();
      drive(1'b0, ISA_ADD_OP, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
      tests_run++;
      if (wbv !== {1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL illegal_wb got %b want %b", wbv, {1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1});
      end
      tick();
   endtask

   task automatic test_latency2();
      drive(1'b0, ISA_ADD_OP, 5'd0, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1'b1, ISA_MUL_OP, 5'd1, 1'b1, 1'b1);
      @(negedge clock);
      tests_run++;
      if ({l2_issue_ready, l2_mul_start, l2_wb_valid} !== 3'b110) begin
         tests_failed++;
         $display("FAIL l2_first_mul got ready/start/wb=%b want 110",
                  {l2_issue_ready, l2_mul_start, l2_wb_valid});
      end
      tick();
      drive(1'b1, ISA_MUL_OP, 5'd2, 1'b1, 1'b1);
      @(negedge clock);
      tests_run++;
      if ({l2_issue_ready, l2_mul_start, l2_wb_valid} !== 3'b000) begin
         tests_failed++;
         $display("FAIL l2_busy got ready/start/wb=%b want 000",
                  {l2_issue_ready, l2_mul_start, l2_wb_valid});
      end
      tick();
      @(negedge clock);
      tests_run++;
      if ({l2_issue_ready, l2_mul_start} !== 2'b11 || l2_wbv !== {1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL l2_first_wb got ready/start=%b wbv=%b want 11 %b",
                  {l2_issue_ready, l2_mul_start}, l2_wbv, {1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0});
      end
      tick();
      drive(1'b0, ISA_ADD_OP, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
      tests_run++;
      if ({l2_issue_ready, l2_wb_valid} !== 2'b00) begin
         tests_failed++;
         $display("FAIL l2_second_busy got ready/wb=%b want 00", {l2_issue_ready, l2_wb_valid});
      end
      tick();
      @(negedge clock);
      tests_run++;
      if (l2_wbv !== {1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL l2_second_wb got %b want %b", l2_wbv, {1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0});
      end
      tick();
   endtask

   typedef struct {
      int                cyc;
      logic [REG_AW-1:0] dest;
      logic              w;
      logic              c;
      logic              m;
      logic              ill;
   } wb_event_t;

   task automatic test_random();
      wb_event_t         q[$];
      wb_event_t         ev;
      int                mul_t;
      logic              v, w, c, fl, busy, exp_ready, acc, is_add, is_sub, is_mul, due;
      logic [OP_W-1:0]   op;
      logic [REG_AW-1:0] d;
      logic [2:0]        exp_ctl;
      logic [9:0]        exp_wb;
      int                r;

      drive(1'b0, ISA_ADD_OP, 5'd0, 1'b0, 1'b0);
      flush = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mul_t = -100;
      for (int cyc = 0; cyc < 500; cyc++) begin
         v = ($urandom_range(0, 9) < 7);
         r = $urandom_range(0, 9);
         if (r < 3) op = ISA_ADD_OP;
         else if (r < 5) op = ISA_SUB_OP;
         else if (r < 7) op = ISA_MUL_OP;
         else op = OP_W'($urandom_range(3, 15));
         d = REG_AW'($urandom);
         w = 1'($urandom);
         c = 1'($urandom);
         due = (q.size() > 0) && (q[0].cyc == cyc);
         // Keep flushes off cycles where a single-cycle result is due.
         fl = ($urandom_range(0, 19) == 0) && !(due && !q[0].m);
         drive(v, op, d, w, c);
         flush = fl;

         is_add    = (op == ISA_ADD_OP);
         is_sub    = (op == ISA_SUB_OP);
         is_mul    = (op == ISA_MUL_OP);
         busy      = (cyc > mul_t) && (cyc < mul_t + LAT);
         exp_ready = !fl && !busy;
         acc       = v && exp_ready;
         exp_ctl   = {exp_ready, acc && (is_add || is_sub), acc && is_mul};
         exp_wb    = '0;
         if (due && !(fl && q[0].m))
            exp_wb = {1'b1, q[0].m, q[0].dest, q[0].w, q[0].c, q[0].ill};
         if (due) void'(q.pop_front());

         @(negedge clock);
         tests_run++;
         if ({issue_ready, alu_start, mul_start} !== exp_ctl ||
             (exp_ctl[1] && alu_sub !== is_sub)) begin
            tests_failed++;
            $display("FAIL rand_ctl cyc %0d got ready/alu/mul=%b sub=%b want %b sub=%b",
                     cyc, {issue_ready, alu_start, mul_start}, alu_sub, exp_ctl, is_sub);
         end
         tests_run++;
         if (exp_wb[9] ? (wbv !== exp_wb)
                       : ({wb_valid, wb_reg_write, wb_commit} !== 3'b000)) begin
            tests_failed++;
            $display("FAIL rand_wb cyc %0d got %b want %b", cyc, wbv, exp_wb);
         end

         if (acc) begin
            ev.cyc  = is_mul ? cyc + LAT : cyc + 1;
            ev.dest = d;
            ev.ill  = !(is_add || is_sub || is_mul);
            ev.w    = w && !ev.ill;
            ev.c    = c;
            ev.m    = is_mul;
            q.push_back(ev);
            if (is_mul) mul_t = cyc;
         end
         if (fl) begin
            q.delete();
            mul_t = -100;
         end
         tick();
      end
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alu_back_to_back();
      test_mul_stall();
      test_flush_mul();
      test_illegal();
      test_latency2();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
